// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//   Routes a single valid/ready input stream to one of four output channels.
//   Each channel owns a one-entry holding register (valid flag + data word)
//   that drives its outputs directly. Words aimed at a disabled channel are
//   accepted and discarded, and a saturating counter records how many.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : input word present
//   in_ready   : input word accepted this cycle (combinational)
//   in_data    : input word, WIDTH bits
//   in_sel     : destination channel 0..3
//   chan_en    : per-channel enable, bit i enables channel i
//   out_valid  : bit i set while channel i holds a word
//   out_ready  : bit i set when the channel i consumer takes the word
//   out_data   : channel i word at [i*WIDTH +: WIDTH]
//   drop_cnt   : saturating count of words dropped to disabled channels
// -----------------------------------------------------------------------------
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic [3:0]         chan_en,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]   drop_cnt
);

  logic [3:0]            valid_r;
  logic [3:0][WIDTH-1:0] data_r;
  logic [CNT_W-1:0]      drop_cnt_r;

  logic       sel_en_s;
  logic       sel_busy_s;
  logic       in_ready_s;
  logic       xfer_s;
  logic       drop_s;
  logic [3:0] load_s;

  // Acceptance decode: a disabled target always accepts (the word is dropped);
  // an enabled target accepts when its slot is empty or is draining this edge.
  always_comb begin
    sel_en_s   = chan_en[in_sel];
    sel_busy_s = valid_r[in_sel] & ~out_ready[in_sel];
    in_ready_s = ~sel_en_s | ~sel_busy_s;
    xfer_s     = in_valid & in_ready_s;
    drop_s     = xfer_s & ~sel_en_s;
    if (xfer_s && sel_en_s) begin
      load_s = 4'b0001 << in_sel;
    end else begin
      load_s = 4'b0000;
    end
  end

  // Channel holding registers: a load wins over a drain on the same edge so a
  // full channel can stream with no bubble; data is left in place after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 4'b0000;
      data_r  <= {(4*WIDTH){1'b0}};
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load_s[i]) begin
          valid_r[i] <= 1'b1;
          data_r[i]  <= in_data;
        end else if (out_ready[i]) begin
          // Clearing an already-empty flag is harmless, so out_ready on an
          // empty channel has no visible effect.
          valid_r[i] <= 1'b0;
        end else begin
          valid_r[i] <= valid_r[i];
        end
      end
    end
  end

  // Drop counter: counts discarded words and sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= {CNT_W{1'b0}};
    end else if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//   Self-checking bench for stream_demux. A behavioural model of four
//   one-word channels and a saturating drop count predicts every output.
//   A second instance with CNT_W=2 shares the stimulus to exercise saturation.
// -----------------------------------------------------------------------------
module tb_stream_demux;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  chan_en;
  logic [3:0]  out_ready;

  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [7:0]  drop_cnt;

  logic        in_ready2;
  logic [3:0]  out_valid2;
  logic [31:0] out_data2;
  logic [1:0]  drop_cnt2;

  int total;
  int bad;

  // behavioural model state
  logic [3:0] mvalid;
  logic [7:0] mdata [4];
  int         mdrop;
  int         mdrop2;

  stream_demux #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .chan_en(chan_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  stream_demux #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_sel(in_sel),
    .chan_en(chan_en),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .drop_cnt(drop_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data();
    return {mdata[3], mdata[2], mdata[1], mdata[0]};
  endfunction

  task automatic model_clear();
    mvalid = 4'b0000;
    for (int i = 0; i < 4; i++) mdata[i] = 8'h00;
    mdrop  = 0;
    mdrop2 = 0;
  endtask

  // Drive one cycle of inputs (called at negedge), check everything against
  // the model, then advance the model across the rising edge.
  task automatic step(input logic v, input logic [1:0] sel, input logic [7:0] d,
                      input logic [3:0] en, input logic [3:0] rdy);
    logic exp_rdy;
    logic accept;
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    chan_en   = en;
    out_ready = rdy;
    #1;
    exp_rdy = !en[sel] || !mvalid[sel] || rdy[sel];
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("in_ready_sat", {31'd0, in_ready2}, {31'd0, exp_rdy});
    chk("out_valid", {28'd0, out_valid}, {28'd0, mvalid});
    chk("out_valid_sat", {28'd0, out_valid2}, {28'd0, mvalid});
    chk("out_data", out_data, exp_data());
    chk("drop_cnt", {24'd0, drop_cnt}, mdrop);
    chk("drop_cnt_sat", {30'd0, drop_cnt2}, mdrop2);
    @(posedge clk);
    accept = v && exp_rdy && !rst;
    for (int i = 0; i < 4; i++) begin
      if (accept && en[sel] && (sel == i)) begin
        mvalid[i] = 1'b1;
        mdata[i]  = d;
      end else if (!rst && mvalid[i] && rdy[i]) begin
        mvalid[i] = 1'b0;
      end
    end
    if (accept && !en[sel]) begin
      if (mdrop < 255) mdrop++;
      if (mdrop2 < 3) mdrop2++;
    end
    @(negedge clk);
  endtask

  // Reset with transfers offered during it; they must be ignored.
  task automatic apply_reset();
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    step(1'b1, 2'd1, 8'hEE, 4'hF, 4'h0);
    step(1'b1, 2'd2, 8'hDD, 4'h0, 4'h0);
    rst = 1'b0;
  endtask

  task automatic random_run(input int n);
    for (int k = 0; k < n; k++) begin
      logic [3:0] en;
      en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      step(1'($urandom), 2'($urandom), 8'($urandom), en, 4'($urandom));
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sel = 2'd0;
    in_data = 8'h00;
    chan_en = 4'h0;
    out_ready = 4'h0;
    model_clear();
    @(negedge clk);
    apply_reset();

    // Fill all four channels with no consumer ready.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 8'hA0 + 8'(i), 4'hF, 4'h0);
    chk("fill_valid", {28'd0, out_valid}, 32'h0000000F);
    chk("fill_data", out_data, 32'hA3A2A1A0);
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      #1;
      chk("fill_ready", {31'd0, in_ready}, 32'd0);
    end

    // Drain everything, then stall channel 2 and pass through.
    step(1'b0, 2'd0, 8'h00, 4'hF, 4'hF);
    step(1'b1, 2'd2, 8'h11, 4'hF, 4'h0);
    step(1'b1, 2'd2, 8'h22, 4'hF, 4'h0);
    step(1'b1, 2'd2, 8'h22, 4'hF, 4'h0);
    chk("stall_hold", {24'd0, out_data[23:16]}, 32'h11);
    chk("stall_valid", {31'd0, out_valid[2]}, 32'd1);
    step(1'b1, 2'd2, 8'h22, 4'hF, 4'b0100);
    chk("pass_valid", {31'd0, out_valid[2]}, 32'd1);
    chk("pass_data", {24'd0, out_data[23:16]}, 32'h22);
    step(1'b0, 2'd0, 8'h00, 4'hF, 4'hF);

    // Back-to-back stream of 16 words into channel 1.
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 2'd1, 8'h30 + 8'(k), 4'hF, 4'b0010);
      chk("stream_valid", {31'd0, out_valid[1]}, 32'd1);
      chk("stream_data", {24'd0, out_data[15:8]}, 32'h30 + k);
    end
    step(1'b0, 2'd0, 8'h00, 4'hF, 4'hF);

    // Disabled channel 0: words dropped, counter saturates on the CNT_W=2 copy.
    for (int k = 0; k < 3; k++) step(1'b1, 2'd0, 8'h40 + 8'(k), 4'b1110, 4'h0);
    chk("drop3_cnt", {24'd0, drop_cnt}, 32'd3);
    chk("drop3_valid", {31'd0, out_valid[0]}, 32'd0);
    for (int k = 0; k < 2; k++) step(1'b1, 2'd0, 8'h50, 4'b1110, 4'h0);
    chk("drop5_cnt", {24'd0, drop_cnt}, 32'd5);
    chk("drop5_sat", {30'd0, drop_cnt2}, 32'd3);

    // Channel 3 holds a word, then is disabled: word still delivered.
    step(1'b1, 2'd3, 8'h5A, 4'hF, 4'h0);
    step(1'b0, 2'd0, 8'h00, 4'b0111, 4'h0);
    step(1'b1, 2'd3, 8'h77, 4'b0111, 4'h0);
    chk("dis_hold_valid", {31'd0, out_valid[3]}, 32'd1);
    chk("dis_hold_data", {24'd0, out_data[31:24]}, 32'h5A);
    step(1'b0, 2'd0, 8'h00, 4'b0111, 4'b1000);
    chk("dis_drained", {31'd0, out_valid[3]}, 32'd0);
    chk("dis_drained_data", {24'd0, out_data[31:24]}, 32'h5A);

    random_run(400);

    // Mid-operation asynchronous reset with all channels full.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 8'hC0 + 8'(i), 4'hF, 4'h0);
    step(1'b1, 2'd0, 8'h99, 4'h0, 4'h0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", {28'd0, out_valid}, 32'd0);
    chk("async_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("async_cnt_sat", {30'd0, drop_cnt2}, 32'd0);
    chk("async_data", out_data, 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    // First edge after release must accept.
    step(1'b1, 2'd2, 8'h3C, 4'hF, 4'h0);
    chk("post_rst_valid", {28'd0, out_valid}, 32'h4);

    random_run(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, meaning drop counter width in bits.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the input word is present.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the input word this cycle.
REQ-008 SHALL have port in_data, input, WIDTH bits: the input word.
REQ-009 SHALL have port in_sel, input, 2 bits: the destination channel, 0..3.
REQ-010 SHALL have port chan_en, input, 4 bits: per-channel enable; bit i enables channel i.
REQ-011 SHALL have port out_valid, output, 4 bits: bit i means channel i holds a word.
REQ-012 SHALL have port out_ready, input, 4 bits: bit i means the channel i consumer takes the word.
REQ-013 SHALL have port out_data, output, 4*WIDTH bits: channel i word at bits [i*WIDTH +: WIDTH].
REQ-014 SHALL have port drop_cnt, output, CNT_W bits: count of words dropped to disabled channels.

Function
REQ-015 SHALL give each channel a one-entry holding register, consisting of a valid flag and a WIDTH-bit data register, driving out_valid[i] and the channel i slice of out_data directly.
REQ-016 SHALL drive in_ready combinationally as: !chan_en[in_sel] OR !out_valid[in_sel] OR out_ready[in_sel].
REQ-017 SHALL treat an input transfer as occurring on a rising edge where in_valid and in_ready are both 1; in_data and in_sel are sampled on that edge.
REQ-018 SHALL, on a transfer with chan_en[in_sel]=1, load in_data into the in_sel holding register and set its valid flag; out_valid rises 1 cycle after the accept edge.
REQ-019 SHALL clear out_valid[i] after an edge where out_valid[i] and out_ready[i] are both 1, unless the same edge loads channel i.
REQ-020 SHALL, on simultaneous drain and load of the same channel, keep out_valid[i]=1 and replace the data; this gives full throughput with no bubble.
REQ-021 SHALL keep out_data slice i and out_valid[i] stable while out_valid[i]=1 and out_ready[i]=0.
REQ-022 SHALL let out_data slice i retain its last value after a drain; it is not cleared.
REQ-023 SHALL operate channels independently: a stalled channel never blocks transfers to other channels.
REQ-024 SHALL, on a transfer with chan_en[in_sel]=0, discard the word, leave all holding registers unchanged, and increment drop_cnt by 1.
REQ-025 SHALL saturate drop_cnt at all-ones; it does not wrap.
REQ-026 SHALL still deliver a word already held when its channel is disabled; chan_en gates loads only, never drains.
REQ-027 SHALL ignore out_ready[i] while out_valid[i]=0.
REQ-028 SHALL make in_sel, in_data and chan_en do nothing when in_valid=0.

Reset
REQ-029 SHALL, while rst=1, immediately force out_valid=4'b0000, out_data=all zeros and drop_cnt=0, independent of clk.
REQ-030 SHALL drive in_ready by REQ-016 during reset, but SHALL ignore transfers while rst=1.
REQ-031 SHALL discard held words when reset is asserted mid-operation, and SHALL accept transfers from the first rising edge after rst deasserts.

Verification
REQ-032 SHALL cover, with WIDTH=8: reset, then chan_en=4'hF, then one transfer each of in_data=8'hA0..8'hA3 to in_sel=0..3 with out_ready=0 -> out_valid=4'hF, out_data=32'hA3A2A1A0, in_ready=0 for every in_sel.
REQ-033 SHALL cover stall and pass-through: channel 2 full with 8'h11 and out_ready[2]=0, then in_valid=1, in_sel=2, in_data=8'h22 -> in_ready=0 and data held at 8'h11; raise out_ready[2] -> same edge drains 8'h11 and loads 8'h22, out_valid[2] stays 1.
REQ-034 SHALL cover back-to-back streaming: 16 consecutive words to channel 1 with out_ready[1]=1 -> in_ready=1 every cycle and all 16 words appear in order, each 1 cycle after acceptance.
REQ-035 SHALL cover the disabled channel: chan_en=4'b1110, 3 words to in_sel=0 -> in_ready=1, out_valid[0]=0, drop_cnt=3; with CNT_W=2, 5 drops -> drop_cnt=2'b11.
REQ-036 SHALL cover disable while holding: channel 3 holds 8'h5A, chan_en[3] is set to 0 -> out_valid[3] stays 1, and the word drains when out_ready[3]=1.
REQ-037 SHALL cover reset mid-operation: rst asserted between clock edges with all channels full -> out_valid=0 and drop_cnt=0 at once, before the next clk edge.
